// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared state encoding and latency helper for the serial-parallel multiplier
package spm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } spm_state_e;

    // Edges from the accepting edge until done is raised.
    function automatic int spm_latency(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/spm_cell.sv
// rtl/spm_cell.sv - one bit-slice of the serial-parallel multiplier array
module spm_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic mode_i,
    input  logic x_i,
    input  logic y_i,
    input  logic sum_i,
    output logic sum_o
);

    logic s_q, c_q;
    logic s_d, c_d;
    logic a;

    // mode_i=1 turns the slice into a serial two's-complement negator; c_q then remembers a seen 1.
    always_comb begin
        a   = x_i & y_i;
        s_d = 1'b0;
        c_d = 1'b0;
        if (mode_i) begin
            s_d = a ^ c_q;
            c_d = c_q | a;
        end else begin
            {c_d, s_d} = {1'b0, a} + {1'b0, sum_i} + {1'b0, c_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            s_q <= 1'b0;
            c_q <= 1'b0;
        end else if (en_i) begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign sum_o = s_q;

endmodule

// File: rtl/spm_seq_mult.sv
// rtl/spm_seq_mult.sv - serial-parallel multiplier with start/done handshake and signed/unsigned mode
module spm_seq_mult
    import spm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(2 * WIDTH + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(spm_latency(WIDTH) - 1);
    localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);

    spm_state_e          state_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    x_q, y_q;
    logic                sm_q;
    logic                busy_q, done_q;
    logic [2*WIDTH-1:0]  prod_q, prod_d;

    logic                accept;
    logic                cell_en;
    logic                ybit;
    logic [WIDTH-1:0]    y_sh;
    logic [WIDTH-1:0]    s_vec;

    always_comb begin
        accept  = start && (state_q != ST_RUN);
        cell_en = (state_q == ST_RUN) && (cnt_q < CNT_LAST);
        y_sh    = y_q >> cnt_q;
        // Past the top multiplier bit, feed sign extension (signed) or zeros (unsigned).
        ybit    = (cnt_q < CNT_W) ? y_sh[0] : (sm_q & y_q[WIDTH-1]);
        prod_d  = {s_vec[0], prod_q[2*WIDTH-1:1]};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == WIDTH - 1) begin : g_msb
            spm_cell u_cell (
                .clk    (clk),
                .rst    (rst),
                .clr_i  (accept),
                .en_i   (cell_en),
                .mode_i (sm_q),
                .x_i    (x_q[i]),
                .y_i    (ybit),
                .sum_i  (1'b0),
                .sum_o  (s_vec[i])
            );
        end else begin : g_low
            spm_cell u_cell (
                .clk    (clk),
                .rst    (rst),
                .clr_i  (accept),
                .en_i   (cell_en),
                .mode_i (1'b0),
                .x_i    (x_q[i]),
                .y_i    (ybit),
                .sum_i  (s_vec[i+1]),
                .sum_o  (s_vec[i])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x_q     <= x;
                        y_q     <= y;
                        sm_q    <= signed_mode;
                        prod_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    // The cell-0 sum is registered, so capture lags the feed by one edge.
                    if (cnt_q != '0) prod_q <= prod_d;
                    if (cnt_q == CNT_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule
